// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_unit
// Description : RV32I load/store front-end onto a word-wide data memory port;
//               sub-word stores are read-modify-write, faults never touch memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h400
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] resp_bad_addr,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] C_EXC_NONE   = 2'b00;
    localparam logic [1:0] C_EXC_LD_MIS = 2'b01;
    localparam logic [1:0] C_EXC_ST_MIS = 2'b10;
    localparam logic [1:0] C_EXC_FAULT  = 2'b11;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_rdata;
    logic [1:0]  r_exc;
    logic [31:0] r_bad_addr;

    logic        w_accept;
    logic        w_illegal;
    logic        w_range;
    logic        w_misalign;
    logic [1:0]  w_exc;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_merged;
    logic [31:0] w_word_addr;

    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_rdata    = r_rdata;
    assign resp_exc      = r_exc;
    assign resp_bad_addr = r_bad_addr;
    assign w_accept      = req_valid && (r_state == ST_IDLE);
    assign w_word_addr   = {r_addr[31:2], 2'b00};

    // Fault classification of the incoming request; access faults win over misalignment.
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default:                w_illegal = req_we && req_funct3[2];
        endcase
        w_range    = (req_addr >= ADDR_LIMIT);
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (w_illegal || w_range) begin
            w_exc = C_EXC_FAULT;
        end else if (w_misalign) begin
            w_exc = req_we ? C_EXC_ST_MIS : C_EXC_LD_MIS;
        end else begin
            w_exc = C_EXC_NONE;
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_ld_byte = dm_dout[7:0];
            2'b01:   w_ld_byte = dm_dout[15:8];
            2'b10:   w_ld_byte = dm_dout[23:16];
            default: w_ld_byte = dm_dout[31:24];
        endcase
        w_ld_half = r_addr[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = dm_dout;
        endcase
    end

    // Replace the addressed byte or halfword lane of the word read in ACCESS.
    always_comb begin
        w_merged = r_buf;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'b00:   w_merged[7:0]   = r_wdata[7:0];
                2'b01:   w_merged[15:8]  = r_wdata[7:0];
                2'b10:   w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        dm_addr      = 32'd0;
        dm_we        = 1'b0;
        dm_din       = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = (w_exc != C_EXC_NONE) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dm_addr = w_word_addr;
                if (r_we && (r_funct3[1:0] == 2'b10)) begin
                    dm_we        = 1'b1;
                    dm_din       = r_wdata;
                    w_state_next = ST_RESP;
                end else if (r_we) begin
                    w_state_next = ST_MERGE;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            ST_MERGE: begin
                dm_addr      = w_word_addr;
                dm_we        = 1'b1;
                dm_din       = w_merged;
                w_state_next = ST_RESP;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_rdata    <= 32'd0;
            r_exc      <= C_EXC_NONE;
            r_bad_addr <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_funct3   <= req_funct3;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rdata    <= 32'd0;
                r_exc      <= w_exc;
                r_bad_addr <= (w_exc != C_EXC_NONE) ? req_addr : 32'd0;
            end
            if (r_state == ST_ACCESS) begin
                if (r_we) begin
                    r_buf <= dm_dout;
                end else begin
                    r_rdata <= w_ld_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_unit
// Description : Directed scoreboard bench for dm_access_unit with a word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic [31:0] resp_bad_addr;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:255];

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  exc;
        logic [31:0] bad;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   we_cnt = 0;
    logic [31:0] last_we_addr = 32'd0;
    logic [31:0] last_we_din = 32'd0;

    dm_access_unit #(.ADDR_LIMIT(32'h400)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .resp_bad_addr(resp_bad_addr),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr[9:2]];

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[9:2]] <= dm_din;
    end

    // Acceptance timestamps let the monitor measure latency in clock edges.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rstn && req_valid && req_ready) acc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (dm_we) begin
            we_cnt       = we_cnt + 1;
            last_we_addr = dm_addr;
            last_we_din  = dm_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   acc;
        if (rstn && resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                e   = exp_q.pop_front();
                acc = acc_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_exc", {30'd0, resp_exc}, {30'd0, e.exc});
                check("resp_bad_addr", resp_bad_addr, e.bad);
                check("latency", cyc - acc + 1, e.lat);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("resp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic push_exp(input logic [31:0] er, input logic [1:0] ee,
                            input logic [31:0] eb, input int el);
        exp_t e;
        e.rdata = er;
        e.exc   = ee;
        e.bad   = eb;
        e.lat   = el;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er,
                         input logic [1:0] ee, input logic [31:0] eb, input int el);
        int n = 0;
        push_exp(er, ee, eb, el);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();
    endtask

    task automatic garbage();
        req_we     = $urandom_range(0, 1) == 1;
        req_funct3 = 3'b010;
        req_addr   = ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h500;
        req_wdata  = $urandom;
    endtask

    logic        s_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] s_addr [4] = '{32'h100, 32'h100, 32'h104, 32'h104};
    logic [31:0] s_wd   [4] = '{32'hA5A50001, 32'h0, 32'h5A5A0002, 32'h0};
    logic [31:0] s_exp  [4] = '{32'h0, 32'hA5A50001, 32'h0, 32'h5A5A0002};

    initial begin
        int we_before;
        int k;
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4]  = 32'h8899AABB;
        mem[16] = 32'h11223344;

        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_din", dm_din, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_exc_bad", {30'd0, resp_exc} | resp_bad_addr, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Loads from mem[0x10] = 8899AABB
        issue(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 2'b00, 32'h0, 2);
        issue(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 2'b00, 32'h0, 2);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 2'b00, 32'h0, 2);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 2'b00, 32'h0, 2);

        // Sub-word stores via read-modify-write
        we_before = we_cnt;
        issue(1'b1, 3'b000, 32'h13, 32'h12345677, 32'h0, 2'b00, 32'h0, 3);
        check("sb_we_pulses", we_cnt - we_before, 1);
        check("sb_mem", mem[4], 32'h7799AABB);
        issue(1'b1, 3'b001, 32'h10, 32'h0000CAFE, 32'h0, 2'b00, 32'h0, 3);
        check("sh_mem", mem[4], 32'h7799CAFE);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h00007799, 2'b00, 32'h0, 2);
        issue(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFCAFE, 2'b00, 32'h0, 2);

        // Faults: no memory write, single-cycle turnaround
        we_before = we_cnt;
        issue(1'b0, 3'b010, 32'h22,  32'h0, 32'h0, 2'b01, 32'h22,  1);
        issue(1'b1, 3'b001, 32'h23,  32'h0, 32'h0, 2'b10, 32'h23,  1);
        issue(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 2'b11, 32'h400, 1);
        issue(1'b1, 3'b100, 32'h20,  32'h0, 32'h0, 2'b11, 32'h20,  1);
        issue(1'b0, 3'b010, 32'h402, 32'h0, 32'h0, 2'b11, 32'h402, 1);
        issue(1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 2'b11, 32'h10,  1);
        check("fault_no_we", we_cnt - we_before, 0);

        // Top-of-range word store and readback
        we_before = we_cnt;
        issue(1'b1, 3'b010, 32'h3FC, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 2);
        check("sw_we_pulses", we_cnt - we_before, 1);
        check("sw_dm_addr", last_we_addr, 32'h3FC);
        check("sw_dm_din", last_we_din, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 2);

        // Reset during MERGE of SB 0x40
        we_before = we_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h40;
        req_wdata  = 32'h000000FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("merge_we_before_rst", {31'd0, dm_we}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_resp", {31'd0, resp_valid} | resp_rdata | {30'd0, resp_exc} | resp_bad_addr, 32'd0);
        check("rst_mid_dm_addr", dm_addr, 32'd0);
        acc_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("rst_mid_mem", mem[16], 32'h11223344);
        check("rst_mid_no_write", we_cnt - we_before, 0);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 2'b00, 32'h0, 2);

        // req_valid held high with alternating SW/LW; busy-cycle inputs are junk
        @(negedge clk);
        req_valid = 1'b1;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 100) begin
            if (req_ready) begin
                req_we     = s_we[k];
                req_funct3 = 3'b010;
                req_addr   = s_addr[k];
                req_wdata  = s_wd[k];
                push_exp(s_exp[k], 2'b00, 32'h0, 2);
                k++;
            end else begin
                garbage();
            end
            @(negedge clk);
            guard++;
        end
        while (!req_ready && guard < 100) begin
            garbage();
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        check("stream_guard", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
        drain();
        check("stream_mem0", mem[64], 32'hA5A50001);
        check("stream_mem1", mem[65], 32'h5A5A0002);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Load/store front-end between the CPU MEM stage and the word-wide data-memory port (dm_addr/dm_we/dm_din/dm_dout) of the memory subsystem.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, sign/zero-extending load data.
- Sub-word stores are done as read-modify-write.
- Detects misaligned, out-of-range and illegal-size accesses and returns them as exceptions without touching memory.
- CPU side uses a valid/ready request and a one-cycle response pulse; the pipeline stalls while req_ready is low.

Parameters:
- ADDR_LIMIT, 32'h400: first invalid byte address. Default matches the 256-word data memory. Any access with addr >= ADDR_LIMIT faults.

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_exc  out  2  00 none, 01 misaligned load, 10 misaligned store, 11 access fault
- resp_bad_addr  out  32  faulting byte address; 0 when resp_exc=00
- dm_addr  out  32  word-aligned byte address to data memory
- dm_we  out  1  data-memory write enable
- dm_din  out  32  data-memory write word
- dm_dout  in  32  data-memory read word, asynchronous read

Behaviour:
- Clock is clk. Reset is rstn: asynchronous, active-low.
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_exc=0, resp_bad_addr=0, dm_addr=0, dm_we=0, dm_din=0. req_ready=1, because it is decoded from IDLE.
- Request register: on acceptance, latch we, funct3, addr and wdata. Inputs are ignored outside IDLE.
- States:
  - IDLE: req_ready=1. On accept:
    - if a fault applies -> RESP with exc and bad_addr set;
    - else -> ACCESS.
  - ACCESS: dm_addr={addr[31:2],2'b00}.
    - Load: extract the lane, extend, register into resp_rdata -> RESP.
    - SW: dm_we=1, dm_din=wdata -> RESP.
    - SB/SH: capture dm_dout into the merge buffer -> MERGE.
  - MERGE: dm_we=1, dm_din = buffer with the byte/halfword lane replaced by wdata[7:0]/wdata[15:0] at addr[1:0]/addr[1] -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
    - resp_* hold their values until the next acceptance. They are cleared at acceptance.
- Fault priority:
  1. access fault: illegal funct3 (011, 110, 111, or store with funct3[2]=1), or addr >= ADDR_LIMIT;
  2. then misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0.
  - A faulting request never asserts dm_we.
- Latency (acceptance edge t): fault resp_valid at t+1; load and SW at t+2; SB/SH at t+3.
- dm_we is asserted only in ACCESS (SW) or MERGE (SB/SH). It is decoded from state, so async reset drops it immediately.
- Lane order is little-endian: byte n is bits [8n+7:8n].
- Load extension:
  - B/H sign-extend from bit 7/15;
  - BU/HU zero-extend;
  - W passes through.
- Reset mid-RMW: aborts to IDLE with no write unless the MERGE rising edge has already occurred. The CPU must reissue.
- No back-to-back acceptance: minimum spacing is one RESP cycle.
- The memory subsystem's debug port is unaffected. This unit never drives it.

Test Plan:
- Reset, then mem[0x10]=32'h8899AABB. LB 0x11 -> resp_rdata=32'hFFFFFFAA at t+2; LBU 0x11 -> 32'h000000AA; LH 0x12 -> 32'hFFFF8899; LW 0x10 -> 32'h8899AABB.
- SB 0x13 wdata=32'h12345677, mem[0x10]=32'h8899AABB -> ACCESS read, MERGE writes 32'h7799AABB with dm_we high exactly 1 cycle, resp_valid at t+3. Then SH 0x10 wdata=0xCAFE -> mem=32'h7799CAFE.
- LW 0x22 -> resp_valid at t+1, resp_exc=01, bad_addr=0x22, dm_we never high. SH 0x23 -> resp_exc=10. LW 0x400 -> resp_exc=11. Store funct3=100 -> 11.
- SW 0x3FC wdata=32'hDEADBEEF -> single dm_we pulse with dm_addr=0x3FC and dm_din=32'hDEADBEEF, resp_valid at t+2. Readback LW 0x3FC equals 32'hDEADBEEF.
- Assert rstn low in MERGE before its edge for SB 0x40 -> dm_we drops immediately, memory unchanged, state IDLE, req_ready=1, all resp_* = 0.
- Hold req_valid high continuously with alternating LW/SW: each accepted only in IDLE, exactly one resp_valid per request, ignored inputs during busy cycles do not alter the latched request.
